// File: rtl/shifter_pkg.sv
// Shared encodings for the multi-cycle shifter: op codes, FSM states and the
// reserved-op test (rotate ops count as reserved when the rotate datapath is absent).
package shifter_pkg;

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_LSL  = 3'b001,
    OP_LSR  = 3'b010,
    OP_ASR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // op[2:1] == 2'b11 is the reserved encoding space
  localparam logic [1:0] OP_RSVD_HI = 2'b11;

  function automatic logic op_reserved(input logic [2:0] op, input logic rot_en);
    return (op[2:1] == OP_RSVD_HI) || (!rot_en && op[2]);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of 0..STEP bits, with the bit that left the word.
// Rotate logic is only built when ROT_EN is set.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STEP   = 1,
  parameter int KW     = $clog2(STEP + 1),
  parameter bit ROT_EN = 1'b0
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [2:0]       op_i,
  input  logic [KW-1:0]    k_i,
  output logic [WIDTH-1:0] data_o,
  output logic             carry_o
);

  // One guard bit beyond the word catches the last bit shifted out
  logic [WIDTH:0]   lsl_w, lsr_w, asr_w;
  logic [WIDTH-1:0] rol_d, ror_d;

  if (ROT_EN) begin : g_rot
    assign rol_d = (data_i << k_i) | (data_i >> (WIDTH - int'(k_i)));
    assign ror_d = (data_i >> k_i) | (data_i << (WIDTH - int'(k_i)));
  end else begin : g_no_rot
    assign rol_d = data_i;
    assign ror_d = data_i;
  end

  always_comb begin
    lsl_w   = {1'b0, data_i} << k_i;
    lsr_w   = {data_i, 1'b0} >> k_i;
    asr_w   = $unsigned($signed({data_i, 1'b0}) >>> k_i);
    data_o  = data_i;
    carry_o = 1'b0;
    case (op_i)
      OP_LSL: begin data_o = lsl_w[WIDTH-1:0]; carry_o = lsl_w[WIDTH]; end
      OP_LSR: begin data_o = lsr_w[WIDTH:1];   carry_o = lsr_w[0];     end
      OP_ASR: begin data_o = asr_w[WIDTH:1];   carry_o = asr_w[0];     end
      OP_ROL: begin data_o = rol_d;            carry_o = rol_d[0];     end
      OP_ROR: begin data_o = ror_d;            carry_o = ror_d[WIDTH-1]; end
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: up to STEP bits per clock, valid/ready on both sides.
// Define SEQ_SHIFTER_ROTATE_EN to build ROL/ROR; otherwise they report out_err.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int AW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  input  logic [AW-1:0]    in_amt,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_err
);

`ifdef SEQ_SHIFTER_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  localparam int            KW     = $clog2(STEP + 1);
  localparam logic [AW-1:0] W_A    = AW'(WIDTH);
  localparam logic [AW-1:0] STEP_A = AW'(STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       op_q, op_d;
  logic [AW-1:0]    rem_q, rem_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;

  logic [AW-1:0]    eff_amt;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] step_data;
  logic             step_carry;

  // Shifts saturate at WIDTH, rotates wrap, everything else does no work
  always_comb begin
    eff_amt = '0;
    if (!op_reserved(in_op, ROT_EN)) begin
      case (in_op)
        OP_LSL, OP_LSR, OP_ASR: eff_amt = (in_amt > W_A) ? W_A : in_amt;
        OP_ROL, OP_ROR:         eff_amt = in_amt % W_A;
        default: ;
      endcase
    end
  end

  assign k = (rem_q < STEP_A) ? rem_q[KW-1:0] : KW'(STEP);

  shift_step #(.WIDTH(WIDTH), .STEP(STEP), .KW(KW), .ROT_EN(ROT_EN)) u_step (
    .data_i (data_q),
    .op_i   (op_q),
    .k_i    (k),
    .data_o (step_data),
    .carry_o(step_carry)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    op_d      = op_q;
    rem_d     = rem_q;
    carry_d   = carry_q;
    err_d     = err_q;
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (in_valid && !flush) begin
          data_d  = in_data;
          op_d    = in_op;
          rem_d   = eff_amt;
          carry_d = 1'b0;
          err_d   = op_reserved(in_op, ROT_EN);
          state_d = (eff_amt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          data_d  = step_data;
          carry_d = step_carry;
          rem_d   = rem_q - AW'(k);
          if (rem_d == '0) state_d = ST_DONE;
        end
      end
      ST_DONE: if (flush || out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      op_q    <= OP_PASS;
      rem_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign out_data  = data_q;
  assign out_carry = carry_q;
  assign out_zero  = (data_q == '0);
  assign out_err   = err_q;

endmodule
